// File: rtl/stall_arb_pkg.sv
// Shared types and default sizing for the stall arbiter.
package stall_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int unsigned N_REQ_DEF        = 4;
  localparam int unsigned MAX_HOLD_DEF     = 8;
  localparam int unsigned STARVE_LIMIT_DEF = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping to index 0.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     any
);

  localparam int unsigned PtrW = $clog2(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  int unsigned        sel_idx;

  // Lower copy masked below ptr, upper copy unmasked provides the wrap-around.
  always_comb begin
    dbl     = '0;
    sel_idx = 0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      dbl[j]         = req[j] && (j >= int'(ptr));
      dbl[j + N_REQ] = req[j];
    end
    for (int j = 2 * int'(N_REQ) - 1; j >= 0; j--) begin
      if (dbl[j]) sel_idx = j;
    end
    sel = (sel_idx >= N_REQ) ? PtrW'(sel_idx - N_REQ) : PtrW'(sel_idx);
    any = |req;
  end

endmodule

// File: rtl/stall_arbiter.sv
// Round-robin arbiter for buffer drain access with bounded tenure and a one-cycle gap.
// Optional starvation flags are built when STALL_ARB_STARVE_EN is defined.
module stall_arbiter
  import stall_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = N_REQ_DEF,
  parameter int unsigned MAX_HOLD     = MAX_HOLD_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [N_REQ-1:0]         starve
);

  localparam int unsigned PtrW  = $clog2(N_REQ);
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              grant_valid_q, grant_valid_d;
  logic [PtrW-1:0]   grant_id_q, grant_id_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;

  logic [PtrW-1:0]   sel;
  logic              any;
  logic              hold_max;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req(req),
    .ptr(ptr_q),
    .sel(sel),
    .any(any)
  );

  assign hold_max = (hold_cnt_q == HoldW'(MAX_HOLD));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (any) begin
          grant_d[sel] = 1'b1;
          grant_id_d   = sel;
          hold_cnt_d   = HoldW'(1);
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (!req[grant_id_q] || hold_max) begin
          grant_d = '0;
          // Owner goes to the back of the round-robin order.
          ptr_d   = (grant_id_q == PtrW'(N_REQ - 1)) ? '0 : grant_id_q + PtrW'(1);
          state_d = GAP;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

`ifdef STALL_ARB_STARVE_EN
  localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);

  logic [N_REQ-1:0][WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [N_REQ-1:0]            starve_q, starve_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    starve_d   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!req[i] || grant_q[i]) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != WaitW'(STARVE_LIMIT)) begin
        wait_cnt_d[i] = wait_cnt_q[i] + WaitW'(1);
      end
      starve_d[i] = (wait_cnt_d[i] >= WaitW'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      starve_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = STARVE_LIMIT;
  assign starve              = '0;
`endif

endmodule

// File: tb/tb_stall_arbiter.sv
// Directed-vector bench for stall_arbiter (N_REQ=4, MAX_HOLD=8, STARVE_LIMIT=4).
module tb_stall_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] starve;

  int checks   = 0;
  int failures = 0;

  stall_arbiter #(
    .N_REQ(4),
    .MAX_HOLD(8),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .starve(starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after a clock edge with reset released and req=0.
  task automatic do_reset();
    req   = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    #3;
    checks++;
    if (grant !== 4'b0 || grant_valid !== 1'b0 || grant_id !== 2'd0 || starve !== 4'b0) begin
      failures++;
      $display("FAIL reset_hold grant=%b valid=%b id=%0d starve=%b expected all zero",
               grant, grant_valid, grant_id, starve);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0 || grant_valid !== 1'b0 || grant_id !== 2'd0 || starve !== 4'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d grant=%b valid=%b id=%0d starve=%b expected all zero",
                 c, grant, grant_valid, grant_id, starve);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] exp;
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp = (c <= 8 || c == 11) ? 4'b0100 : 4'b0000;
      checks++;
      if (grant !== exp || grant_valid !== (exp != 4'b0)) begin
        failures++;
        $display("FAIL single cyc=%0d grant=%b valid=%b expected grant=%b", c, grant,
                 grant_valid, exp);
      end
      if (c == 1) begin
        checks++;
        if (grant_id !== 2'd2) begin
          failures++;
          $display("FAIL single_id grant_id=%0d expected 2", grant_id);
        end
      end
    end
  endtask

  task automatic test_rr_order();
    logic [3:0] exp;
    int         owner;
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 41; c++) begin
      tick();
      owner = ((c - 1) / 10) % 4;
      exp   = ((c - 1) % 10 < 8) ? (4'b0001 << owner) : 4'b0000;
      checks++;
      if (grant !== exp || grant_valid !== (exp != 4'b0)) begin
        failures++;
        $display("FAIL rr_order cyc=%0d grant=%b valid=%b expected grant=%b", c, grant,
                 grant_valid, exp);
      end
      if (exp != 4'b0 && grant_id !== 2'(owner)) begin
        failures++;
        $display("FAIL rr_order_id cyc=%0d grant_id=%0d expected %0d", c, grant_id, owner);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] exp;
    do_reset();
    req = 4'b0110;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) req = 4'b0100;
      exp = (c <= 3) ? 4'b0010 : (c == 6) ? 4'b0100 : 4'b0000;
      checks++;
      if (grant !== exp) begin
        failures++;
        $display("FAIL early_release cyc=%0d grant=%b expected %b", c, grant, exp);
      end
    end
    checks++;
    if (grant_id !== 2'd2) begin
      failures++;
      $display("FAIL early_release_id grant_id=%0d expected 2", grant_id);
    end
  endtask

  task automatic test_short_tenure();
    logic [3:0] exp;
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      if (c == 2) req = 4'b1000;
      exp = (c == 1) ? 4'b0001 : (c == 4) ? 4'b1000 : 4'b0000;
      checks++;
      if (grant !== exp) begin
        failures++;
        $display("FAIL short_tenure cyc=%0d grant=%b expected %b", c, grant, exp);
      end
    end
    checks++;
    if (grant_id !== 2'd3) begin
      failures++;
      $display("FAIL short_tenure_id grant_id=%0d expected 3", grant_id);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req = 4'b0011;
    for (int c = 1; c <= 12; c++) tick();
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL mid_busy_setup grant=%b expected 0010", grant);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL async_reset grant=%b valid=%b id=%0d expected all zero", grant,
               grant_valid, grant_id);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_ptr grant=%b id=%0d expected 0001 id 0", grant, grant_id);
    end
  endtask

  task automatic test_starve();
    logic exp1;
    do_reset();
    req = 4'b0011;
    for (int c = 1; c <= 12; c++) begin
      tick();
`ifdef STALL_ARB_STARVE_EN
      exp1 = (c >= 4 && c <= 11);
`else
      exp1 = 1'b0;
`endif
      checks++;
      if (starve[1] !== exp1 || starve[0] !== 1'b0 || starve[3:2] !== 2'b00) begin
        failures++;
        $display("FAIL starve cyc=%0d starve=%b expected bit1=%b others 0", c, starve, exp1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    test_reset();
    test_single();
    test_rr_order();
    test_early_release();
    test_short_tenure();
    test_reset_mid_busy();
    test_starve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
